uart_host_cmd_framer: RTL and testbench
=======================================

// Module: uart_host_cmd_framer
// PURPOSE
//  Host-side command serializer that sits directly upstream of the system's RX_IN pin.
//  Takes one parallel command, expands it into its UART byte sequence and serializes
//  each byte as a UART frame on TX_OUT:
//    WR  = AA,addr,data      RD  = BB,addr
//    ALU = CC,A,B,fun        NOP = DD,fun
//  Used as a synthesizable stimulus/host model for the multi-clock system and on FPGA bring-up.
// PARAMETERS
//  DW        8  data/byte width
//  ADDR_W    3  register-file address width (zero-extended into the byte)
//  FUNCT_W   4  ALU function width (zero-extended into the byte)
//  GAP_BITS  1  idle bit-times (TX_OUT=1) inserted after every stop bit, 0..15
// PORTS
//  CLK        in   1        UART oversampling clock (same clock as UART_CLK domain)
//  RST        in   1        synchronous, active-low reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        framer idle, able to accept
//  cmd_type   in   2        0=WR 1=RD 2=ALU 3=NOP
//  cmd_addr   in   ADDR_W   RF address (WR/RD)
//  cmd_wdata  in   DW       RF write data (WR)
//  cmd_op_a   in   DW       operand A (ALU)
//  cmd_op_b   in   DW       operand B (ALU)
//  cmd_fun    in   FUNCT_W  ALU function (ALU/NOP)
//  prescale   in   6        CLK cycles per bit (8/16/32 nominal)
//  par_en     in   1        parity bit enable
//  par_typ    in   1        0=even 1=odd
//  TX_OUT     out  1        serial line, idle high
//  busy       out  1        command in progress
//  frame_done out  1        1-cycle pulse at end of each stop bit
// BEHAVIOUR
//  Reset: TX_OUT=1, busy=0, cmd_ready=1, frame_done=0. All state returns to IDLE.
//  Reset mid-frame: line is high on the next edge and the command is discarded.
//  Accept: cmd_valid && cmd_ready at edge N.
//    - All cmd_* fields and prescale/par_en/par_typ are latched at edge N.
//    - Input changes during the command are ignored.
//    - busy=1 and cmd_ready=0 from N+1; TX_OUT=0 (start bit) from N+1.
//  FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY if par_en] -> STOP -> GAP -> START|IDLE.
//    - GAP is skipped when GAP_BITS=0.
//    - Each bit, including each GAP bit, is held exactly prescale_q CLK cycles.
//    - prescale_q < 2 is forced to 2.
//  Parity bit: even = ^byte; odd = ~^byte.
//  Byte index counts 0..N-1 with N = 3/2/4/2 for WR/RD/ALU/NOP.
//    - Next byte starts immediately after STOP (+GAP).
//    - After the last byte (+GAP): IDLE; busy=0 and cmd_ready=1 on the following edge.
//  frame_done pulses in the last cycle of every stop bit.
//  cmd_valid while busy has no effect; no queuing.
//  Total command length (cycles) = N * (10 + par_en + GAP_BITS) * prescale_q.
// CONFIGURATION
//  `UART_HOST_ERR_INJ_EN defined:
//    - Adds input inj_par_err (1 bit).
//    - A 1 sampled at accept inverts the parity bit of byte 0 only; no effect if par_en=0.
//    - Used to provoke par_err downstream.
//  Not defined: port absent; parity always correct.
// STRUCTURE
//  Package uart_host_pkg:
//    - opcode constants OP_WR=8'hAA, OP_RD=8'hBB, OP_ALU=8'hCC, OP_NOP=8'hDD
//    - cmd_type encodings
//    - FSM state encoding
//    - per-type byte-count constants
//  Sub-module uart_bit_timer:
//    - prescale-cycle down-counter with load and bit_end pulse
//    - framer FSM and byte mux stay in this module
// TESTING
//  1. Reset held 3 cycles mid-frame -> TX_OUT=1, busy=0, cmd_ready=1 on the edge after RST low.
//  2. WR addr=6 data=FF, prescale=32, par even, GAP=1 ->
//     frames AA,06,FF each 11 bits x32 cycles; parity 0,0,0; 3 frame_done pulses.
//  3. ALU A=03 B=06 fun=2, prescale=16, par odd ->
//     bytes CC,03,06,02; odd-parity bits 1,1,1,0; ready after 4*12*16 cycles.
//  4. NOP fun=4, prescale=8, par off ->
//     DD,04 as 10-bit frames; prescale changed to 32 mid-command has no effect.
//  5. cmd_valid held while busy with a different command ->
//     ignored; the second command is accepted only once cmd_ready=1.
//  6. ERR_INJ: RD addr=7, even, inj=1 -> byte0 BB parity bit 1 (inverted); byte 07 parity correct (1).

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared constants and types for the UART host command framer: opcodes, command types,
// framer FSM states and per-command byte counts.
package uart_host_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdWr  = 2'd0,
    CmdRd  = 2'd1,
    CmdAlu = 2'd2,
    CmdNop = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StGap
  } state_e;

  localparam int unsigned NUM_BYTES_WR  = 3;
  localparam int unsigned NUM_BYTES_RD  = 2;
  localparam int unsigned NUM_BYTES_ALU = 4;
  localparam int unsigned NUM_BYTES_NOP = 2;

  // Index of the final byte of a command sequence.
  function automatic logic [1:0] last_byte_idx(input cmd_type_e t);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (t)
      CmdWr:  idx = 2'(NUM_BYTES_WR - 1);
      CmdRd:  idx = 2'(NUM_BYTES_RD - 1);
      CmdAlu: idx = 2'(NUM_BYTES_ALU - 1);
      CmdNop: idx = 2'(NUM_BYTES_NOP - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loaded with (prescale - 1) at the start of each bit,
// bit_end_o is high during the last cycle of the bit.
module uart_bit_timer #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            bit_end_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_host_cmd_framer.sv
// Host-side UART command framer: expands one parallel command into its opcode/operand
// byte sequence and serializes each byte as a UART frame. Option: UART_HOST_ERR_INJ_EN.
module uart_host_cmd_framer
  import uart_host_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned FUNCT_W  = 4,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_type_i,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic [DW-1:0]      cmd_wdata_i,
  input  logic [DW-1:0]      cmd_op_a_i,
  input  logic [DW-1:0]      cmd_op_b_i,
  input  logic [FUNCT_W-1:0] cmd_fun_i,
  input  logic [5:0]         prescale_i,
  input  logic               par_en_i,
  input  logic               par_typ_i,
`ifdef UART_HOST_ERR_INJ_EN
  input  logic               inj_par_err_i,
`endif
  output logic               tx_out_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam int unsigned CntW    = 5;
  localparam int unsigned BitIdxW = $clog2(DW);
  localparam int unsigned GapLast = (GAP_BITS == 0) ? 0 : GAP_BITS - 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  cmd_type_e          type_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DW-1:0]      wdata_q, op_a_q, op_b_q;
  logic [FUNCT_W-1:0] fun_q;
  logic [5:0]         presc_q;
  logic               par_en_q, par_typ_q, inj_q;

  logic          accept, bit_end_raw, bit_end, byte_done, last_byte;
  logic          timer_load, inj_in, par_bit;
  logic [5:0]    presc_in, timer_val;
  logic [DW-1:0] cur_byte;

`ifdef UART_HOST_ERR_INJ_EN
  assign inj_in = inj_par_err_i;
`else
  assign inj_in = 1'b0;
`endif

  assign accept   = cmd_valid_i && (state_q == StIdle);
  assign presc_in = (prescale_i < 6'd2) ? 6'd2 : prescale_i;
  assign bit_end  = bit_end_raw && (state_q != StIdle);

  // The first bit must time with the prescale being latched this cycle.
  assign timer_load = accept || bit_end;
  assign timer_val  = accept ? (presc_in - 6'd1) : (presc_q - 6'd1);

  uart_bit_timer #(
    .CntW(6)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .bit_end_o  (bit_end_raw)
  );

  assign last_byte = (byte_idx_q == last_byte_idx(type_q));
  assign byte_done = bit_end &&
                     (((state_q == StStop) && (GAP_BITS == 0)) ||
                      ((state_q == StGap) && (cnt_q == CntW'(GapLast))));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          byte_idx_d = '0;
          cnt_d      = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (cnt_q == CntW'(DW - 1)) begin
            state_d = par_en_q ? StParity : StStop;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end && (GAP_BITS != 0)) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (bit_end && !byte_done) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (byte_done) begin
      state_d    = last_byte ? StIdle : StStart;
      byte_idx_d = byte_idx_q + 1'b1;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      type_q     <= CmdWr;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      fun_q      <= '0;
      presc_q    <= 6'd2;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      inj_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      if (accept) begin
        type_q    <= cmd_type_e'(cmd_type_i);
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        op_a_q    <= cmd_op_a_i;
        op_b_q    <= cmd_op_b_i;
        fun_q     <= cmd_fun_i;
        presc_q   <= presc_in;
        par_en_q  <= par_en_i;
        par_typ_q <= par_typ_i;
        inj_q     <= inj_in;
      end
    end
  end

  // Byte mux: opcode first, then operands zero-extended to the byte width.
  always_comb begin
    cur_byte = '0;
    unique case (type_q)
      CmdWr: begin
        unique case (byte_idx_q)
          2'd0:    cur_byte = DW'(OP_WR);
          2'd1:    cur_byte = DW'(addr_q);
          default: cur_byte = wdata_q;
        endcase
      end
      CmdRd: begin
        unique case (byte_idx_q)
          2'd0:    cur_byte = DW'(OP_RD);
          default: cur_byte = DW'(addr_q);
        endcase
      end
      CmdAlu: begin
        unique case (byte_idx_q)
          2'd0:    cur_byte = DW'(OP_ALU);
          2'd1:    cur_byte = op_a_q;
          2'd2:    cur_byte = op_b_q;
          default: cur_byte = DW'(fun_q);
        endcase
      end
      CmdNop: begin
        unique case (byte_idx_q)
          2'd0:    cur_byte = DW'(OP_NOP);
          default: cur_byte = DW'(fun_q);
        endcase
      end
    endcase
  end

  assign par_bit = (par_typ_q ? ~^cur_byte : ^cur_byte) ^ (inj_q && (byte_idx_q == 2'd0));

  always_comb begin
    tx_out_o = 1'b1;
    unique case (state_q)
      StStart:  tx_out_o = 1'b0;
      StData:   tx_out_o = cur_byte[cnt_q[BitIdxW-1:0]];
      StParity: tx_out_o = par_bit;
      default:  tx_out_o = 1'b1;
    endcase
  end

  assign busy_o       = (state_q != StIdle);
  assign cmd_ready_o  = (state_q == StIdle);
  assign frame_done_o = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_uart_host_cmd_framer.sv
// Self-checking bench: a per-cycle expected waveform is built from the command's byte list
// and compared against the DUT every cycle; directed cases pin the model with literals.
`timescale 1ns/1ps
module tb_uart_host_cmd_framer;

  localparam int GapBits = 1;
`ifdef UART_HOST_ERR_INJ_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_type;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata, cmd_op_a, cmd_op_b;
  logic [3:0] cmd_fun;
  logic [5:0] prescale;
  logic       par_en, par_typ, inj_par_err;
  logic       tx_out, busy, frame_done;

  always #5 clk = ~clk;

  uart_host_cmd_framer #(
    .DW(8), .ADDR_W(3), .FUNCT_W(4), .GAP_BITS(GapBits)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_type_i   (cmd_type),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_op_a_i   (cmd_op_a),
    .cmd_op_b_i   (cmd_op_b),
    .cmd_fun_i    (cmd_fun),
    .prescale_i   (prescale),
    .par_en_i     (par_en),
    .par_typ_i    (par_typ),
`ifdef UART_HOST_ERR_INJ_EN
    .inj_par_err_i(inj_par_err),
`endif
    .tx_out_o     (tx_out),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  typedef struct packed {
    logic [1:0] typ;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] fun;
    logic [5:0] presc;
    logic       par_en;
    logic       par_typ;
    logic       inj;
  } cmd_t;

  typedef struct packed {
    logic tx;
    logic busy;
    logic fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   vectors = 0;
  int   errors  = 0;
  int   fd_count = 0;
  bit   chk_en = 1'b0;

  // ---------------- reference model ----------------
  function automatic int model_nbytes(input cmd_t c);
    case (c.typ)
      2'd0: return 3;
      2'd1: return 2;
      2'd2: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] model_byte(input cmd_t c, input int idx);
    logic [7:0] seq [4];
    case (c.typ)
      2'd0: begin seq[0] = 8'hAA; seq[1] = {5'b0, c.addr}; seq[2] = c.wdata; seq[3] = 8'h00; end
      2'd1: begin seq[0] = 8'hBB; seq[1] = {5'b0, c.addr}; seq[2] = 8'h00; seq[3] = 8'h00; end
      2'd2: begin seq[0] = 8'hCC; seq[1] = c.a; seq[2] = c.b; seq[3] = {4'b0, c.fun}; end
      default: begin seq[0] = 8'hDD; seq[1] = {4'b0, c.fun}; seq[2] = 8'h00; seq[3] = 8'h00; end
    endcase
    return seq[idx];
  endfunction

  // Parity bit that makes the total count of ones even (or odd when par_typ=1).
  function automatic logic model_par(input cmd_t c, input int idx);
    logic p;
    p = ($countones(model_byte(c, idx)) % 2) == 1;
    if (c.par_typ) p = !p;
    if (c.inj && idx == 0) p = !p;
    return p;
  endfunction

  task automatic push_model(input cmd_t c);
    int   p;
    int   stop_k;
    logic bits[$];
    exp_t e;
    logic [7:0] v;
    p = (c.presc < 2) ? 2 : int'(c.presc);
    for (int b = 0; b < model_nbytes(c); b++) begin
      bits.delete();
      v = model_byte(c, b);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(v[i]);
      if (c.par_en) bits.push_back(model_par(c, b));
      stop_k = bits.size();
      bits.push_back(1'b1);
      for (int g = 0; g < GapBits; g++) bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++) begin
        for (int cyc = 0; cyc < p; cyc++) begin
          e.tx   = bits[k];
          e.busy = 1'b1;
          e.fd   = (k == stop_k) && (cyc == p - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cur_e = exp_q.pop_front();
      else begin
        cur_e.tx = 1'b1; cur_e.busy = 1'b0; cur_e.fd = 1'b0;
      end
      vectors++;
      if (tx_out !== cur_e.tx || busy !== cur_e.busy || cmd_ready !== !cur_e.busy ||
          frame_done !== cur_e.fd) begin
        errors++;
        if (errors <= 30)
          $display("FAIL cycle @%0t tx/busy/ready/fd: got %b%b%b%b want %b%b%b%b", $time,
                   tx_out, busy, cmd_ready, frame_done,
                   cur_e.tx, cur_e.busy, !cur_e.busy, cur_e.fd);
      end
      if (frame_done === 1'b1) fd_count++;
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input cmd_t c);
    cmd_type    = c.typ;
    cmd_addr    = c.addr;
    cmd_wdata   = c.wdata;
    cmd_op_a    = c.a;
    cmd_op_b    = c.b;
    cmd_fun     = c.fun;
    prescale    = c.presc;
    par_en      = c.par_en;
    par_typ     = c.par_typ;
    inj_par_err = c.inj;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int   pl [8];
    pl = '{0, 1, 2, 3, 5, 8, 16, 32};
    c.typ     = 2'($urandom_range(0, 3));
    c.addr    = 3'($urandom);
    c.wdata   = 8'($urandom);
    c.a       = 8'($urandom);
    c.b       = 8'($urandom);
    c.fun     = 4'($urandom);
    c.presc   = 6'(pl[$urandom_range(0, 7)]);
    c.par_en  = 1'($urandom);
    c.par_typ = 1'($urandom);
    c.inj     = InjEn ? 1'($urandom) : 1'b0;
    return c;
  endfunction

  // Called at posedge+#1 with the DUT idle. Returns at posedge+#1 with the DUT idle again.
  task automatic run_cmd(input cmd_t c, input cmd_t hold, input bit use_hold,
                         input int want_len, input string name);
    drive(c);
    cmd_valid = 1'b1;
    fd_count  = 0;
    @(posedge clk); #1;
    push_model(c);
    if (want_len != 0) check({name, " length"}, exp_q.size(), want_len);
    if (use_hold) begin
      drive(hold);
      cmd_valid = 1'b1;
    end else begin
      drive(rand_cmd());
      cmd_valid = 1'($urandom);
    end
    while (exp_q.size() != 0) @(posedge clk);
    #1;
    check({name, " frame_done pulses"}, fd_count, model_nbytes(c));
    if (!use_hold) cmd_valid = 1'b0;
  endtask

  cmd_t c_wr, c_alu, c_nop, c_rd, c_none;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_wr [3];
    int par_alu [4];
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    drive('0);
    c_none = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", tx_out, 1);
    check("reset busy", busy, 0);
    check("reset ready", cmd_ready, 1);
    check("reset frame_done", frame_done, 0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WR addr=6 data=FF, prescale 32, even parity
    c_wr = '0;
    c_wr.typ = 2'd0; c_wr.addr = 3'd6; c_wr.wdata = 8'hFF; c_wr.presc = 6'd32;
    c_wr.par_en = 1'b1; c_wr.par_typ = 1'b0;
    exp_wr = '{'hAA, 'h06, 'hFF};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("WR model byte%0d", i), model_byte(c_wr, i), exp_wr[i]);
      check($sformatf("WR model parity%0d", i), model_par(c_wr, i), 0);
    end
    run_cmd(c_wr, c_none, 1'b0, 3 * 12 * 32, "WR");

    // ALU CC,03,06,02 odd parity, then a NOP held on cmd_valid while busy
    c_alu = '0;
    c_alu.typ = 2'd2; c_alu.a = 8'h03; c_alu.b = 8'h06; c_alu.fun = 4'd2; c_alu.presc = 6'd16;
    c_alu.par_en = 1'b1; c_alu.par_typ = 1'b1;
    c_nop = '0;
    c_nop.typ = 2'd3; c_nop.fun = 4'd4; c_nop.presc = 6'd8;
    par_alu = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++)
      check($sformatf("ALU model parity%0d", i), model_par(c_alu, i), par_alu[i]);
    check("ALU model byte3", model_byte(c_alu, 3), 'h02);
    run_cmd(c_alu, c_nop, 1'b1, 4 * 12 * 16, "ALU");

    // NOP accepted only after ready; prescale scrambled to 32 mid-command
    drive(c_nop);
    cmd_valid = 1'b1;
    fd_count  = 0;
    @(posedge clk); #1;
    push_model(c_nop);
    check("NOP length", exp_q.size(), 2 * 11 * 8);
    check("NOP model byte0", model_byte(c_nop, 0), 'hDD);
    cmd_valid = 1'b0;
    prescale  = 6'd32;
    while (exp_q.size() != 0) @(posedge clk);
    #1;
    check("NOP frame_done pulses", fd_count, 2);

`ifdef UART_HOST_ERR_INJ_EN
    c_rd = '0;
    c_rd.typ = 2'd1; c_rd.addr = 3'd7; c_rd.presc = 6'd8;
    c_rd.par_en = 1'b1; c_rd.par_typ = 1'b0; c_rd.inj = 1'b1;
    check("RD inj model parity0", model_par(c_rd, 0), 1);
    check("RD inj model parity1", model_par(c_rd, 1), 1);
    run_cmd(c_rd, c_none, 1'b0, 0, "RD inj");
`endif

    // Reset mid-frame
    drive(c_alu);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    push_model(c_alu);
    cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid-reset tx", tx_out, 1);
    check("mid-reset busy", busy, 0);
    check("mid-reset ready", cmd_ready, 1);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized commands with random idle gaps and scrambled inputs while busy
    for (int n = 0; n < 40; n++) begin
      run_cmd(rand_cmd(), c_none, 1'b0, 0, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
